l2_wr_bufs: RTL
===============

L2_WR_BUFS -- requirements
Module: l2_wr_bufs

Interface
REQ-001 SHALL have parameter DEPTH, default 2, number of queued write requests (power of 2, >=2).
REQ-002 SHALL have parameter STARVE_MAX, default 8, number of consecutive blocked drain cycles before force_drain asserts.
REQ-003 SHALL use one clock, clk; reset rst is synchronous and active-high.
REQ-004 SHALL have these ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- wr_req_valid  in  1  write request offered
- wr_req_ready  out  1  request accepted when valid&ready
- wr_req_set  in  L2_SET_BITS  target set
- wr_req_way  in  L2_WAY_BITS  target way
- wr_req_mask  in  5  field enables: [0] line, [1] tag, [2] hprot, [3] state, [4] evict_way
- wr_req_line  in  BITS_PER_LINE  line data
- wr_req_tag  in  L2_TAG_BITS  tag data
- wr_req_hprot  in  HPROT_WIDTH  hprot data
- wr_req_state  in  STABLE_STATE_BITS  state data
- wr_req_evict_way  in  L2_WAY_BITS  new evict way for set
- rd_mem_en  in  1  L2 arrays read this cycle; blocks drain
- rd_set  in  L2_SET_BITS  set being read
- set_conflict  out  1  a queued entry targets rd_set
- wr_en_line, wr_en_tag, wr_en_hprot, wr_en_state, wr_en_evict_way  out  1 each  array write strobes
- wr_set, wr_way, wr_data_line, wr_data_tag, wr_data_hprot, wr_data_state, wr_data_evict_way  out  matching input widths  write address/data
- count  out  clog2(DEPTH+1)  queued entries
- force_drain  out  1  request controller to withhold reads

Function
REQ-005 SHALL store accepted requests in FIFO order; wr_req_ready = (count < DEPTH).
REQ-006 SHALL drop a request with wr_req_mask == 0 on handshake (ready asserted, nothing stored, count unchanged).
REQ-007 SHALL make an entry pushed in cycle N eligible to issue in cycle N+1, never in cycle N.
REQ-008 SHALL issue the head entry in any cycle with count > 0 and rd_mem_en == 0: strobes = head mask bits, address/data = head fields, head popped at that cycle's clock edge.
REQ-009 SHALL drive all wr_en_* to 0 when not issuing; address/data outputs are don't-care then.
REQ-010 SHALL, on simultaneous push and pop, leave count unchanged and preserve order.
REQ-011 SHALL wrap read/write pointers modulo DEPTH with no bubble.
REQ-012 SHALL drive set_conflict combinationally = OR over valid entries of (entry.set == rd_set); an entry issuing this cycle still counts.
REQ-013 SHALL keep a stall counter: increment (saturating at STARVE_MAX) each cycle with count > 0 and rd_mem_en == 1; clear on any issue or when count == 0.
REQ-014 SHALL assert force_drain combinationally when stall counter == STARVE_MAX; deassert in the cycle after the next issue.

Reset
REQ-015 SHALL, in any cycle with rst == 1, clear count, pointers, stall counter and all entry valid bits; wr_en_* = 0, force_drain = 0, set_conflict = 0, wr_req_ready = 0.
REQ-016 SHALL discard queued entries on reset mid-operation; no write strobe in the reset cycle; requests offered during reset are not accepted.
REQ-017 SHALL accept requests from the first cycle after rst deasserts.

Structure
REQ-018 SHALL take l2_set_t, l2_way_t, line_t, l2_tag_t, hprot_t, state_t from the shared cache types package; a new packed struct l2_wr_req_t (set, way, mask, data fields) SHALL be added there.
REQ-019 SHALL implement storage as one sub-module, l2_wr_fifo (l2_wr_req_t entries, push/pop, count, per-entry set outputs for conflict compare).

Verification
REQ-020 Reset then push {set=5, way=2, mask=5'b00001, line=X}, rd_mem_en=0 -> wr_en_line=1, wr_set=5, wr_way=2 exactly one cycle later, count returns to 0.
REQ-021 DEPTH=2: push 3 requests back-to-back with rd_mem_en=1 -> third stalls (ready=0, count=2); release rd_mem_en -> writes issue in push order, one per cycle.
REQ-022 Queue entry set=9, rd_set=9 -> set_conflict=1; rd_set=10 -> 0; after entry issues -> 0.
REQ-023 One entry queued, rd_mem_en=1 for 8 cycles -> force_drain=1 in cycle 8; drop rd_mem_en -> issue, force_drain=0 next cycle.
REQ-024 Push mask=0 -> accepted, count stays 0, no strobe; push mask=5'b11111 while count=2 and rst pulsed -> no strobe, count=0 after reset.

Source files
------------

// File: rtl/l2_wr_bufs_pkg.sv
// Shared L2 cache field types plus the queued write-request record used by the write buffers.
package l2_wr_bufs_pkg;

    localparam int unsigned L2_SET_BITS       = 8;
    localparam int unsigned L2_WAY_BITS       = 3;
    localparam int unsigned BITS_PER_LINE     = 128;
    localparam int unsigned L2_TAG_BITS       = 20;
    localparam int unsigned HPROT_WIDTH       = 1;
    localparam int unsigned STABLE_STATE_BITS = 3;

    typedef logic [L2_SET_BITS-1:0]       l2_set_t;
    typedef logic [L2_WAY_BITS-1:0]       l2_way_t;
    typedef logic [BITS_PER_LINE-1:0]     line_t;
    typedef logic [L2_TAG_BITS-1:0]       l2_tag_t;
    typedef logic [HPROT_WIDTH-1:0]       hprot_t;
    typedef logic [STABLE_STATE_BITS-1:0] state_t;

    // mask: [0] line, [1] tag, [2] hprot, [3] state, [4] evict_way
    typedef struct packed {
        l2_set_t    set;
        l2_way_t    way;
        logic [4:0] mask;
        line_t      line;
        l2_tag_t    tag;
        hprot_t     hprot;
        state_t     state;
        l2_way_t    evict_way;
    } l2_wr_req_t;

endpackage

// File: rtl/l2_wr_fifo.sv
// Circular FIFO of write requests; exposes per-entry valid/set so the top can detect read conflicts.
module l2_wr_fifo
    import l2_wr_bufs_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  l2_wr_req_t                   push_data,
    input  logic                         pop,
    output l2_wr_req_t                   head,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic [DEPTH-1:0]             entry_valid,
    output l2_set_t                      entry_set [DEPTH]
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    l2_wr_req_t      mem_q [DEPTH];
    logic [DEPTH-1:0] valid_q;
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0] count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            // The top never pushes when full and never pops when empty, so indices never collide.
            if (push) begin
                valid_q[wr_ptr_q] <= 1'b1;
                wr_ptr_q          <= wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                valid_q[rd_ptr_q] <= 1'b0;
                rd_ptr_q          <= rd_ptr_q + PtrW'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CntW'(1);
                2'b01:   count_q <= count_q - CntW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            entry_set[i] = mem_q[i].set;
        end
    end

    assign head        = mem_q[rd_ptr_q];
    assign count       = count_q;
    assign entry_valid = valid_q;

endmodule

// File: rtl/l2_wr_bufs.sv
// L2 write buffers: queue array writes, drain them whenever the arrays are not being read,
// flag set conflicts with the current read and request a forced drain on starvation.
module l2_wr_bufs
    import l2_wr_bufs_pkg::*;
#(
    parameter int unsigned DEPTH      = 2,
    parameter int unsigned STARVE_MAX = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_req_valid,
    output logic                       wr_req_ready,
    input  l2_set_t                    wr_req_set,
    input  l2_way_t                    wr_req_way,
    input  logic [4:0]                 wr_req_mask,
    input  line_t                      wr_req_line,
    input  l2_tag_t                    wr_req_tag,
    input  hprot_t                     wr_req_hprot,
    input  state_t                     wr_req_state,
    input  l2_way_t                    wr_req_evict_way,
    input  logic                       rd_mem_en,
    input  l2_set_t                    rd_set,
    output logic                       set_conflict,
    output logic                       wr_en_line,
    output logic                       wr_en_tag,
    output logic                       wr_en_hprot,
    output logic                       wr_en_state,
    output logic                       wr_en_evict_way,
    output l2_set_t                    wr_set,
    output l2_way_t                    wr_way,
    output line_t                      wr_data_line,
    output l2_tag_t                    wr_data_tag,
    output hprot_t                     wr_data_hprot,
    output state_t                     wr_data_state,
    output l2_way_t                    wr_data_evict_way,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       force_drain
);

    localparam int unsigned CntW   = $clog2(DEPTH + 1);
    localparam int unsigned StallW = $clog2(STARVE_MAX + 1);

    l2_wr_req_t       push_data, head;
    logic [DEPTH-1:0] entry_valid;
    l2_set_t          entry_set [DEPTH];
    logic             push, issue;
    logic [StallW-1:0] stall_q;

    assign push_data = '{set: wr_req_set, way: wr_req_way, mask: wr_req_mask, line: wr_req_line,
                         tag: wr_req_tag, hprot: wr_req_hprot, state: wr_req_state,
                         evict_way: wr_req_evict_way};

    assign wr_req_ready = !rst && (count < CntW'(DEPTH));
    // Empty-mask requests handshake normally but are never stored.
    assign push         = wr_req_valid && wr_req_ready && (wr_req_mask != 5'd0);
    assign issue        = !rst && (count != '0) && !rd_mem_en;

    l2_wr_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push        (push),
        .push_data   (push_data),
        .pop         (issue),
        .head        (head),
        .count       (count),
        .entry_valid (entry_valid),
        .entry_set   (entry_set)
    );

    assign wr_en_line        = issue && head.mask[0];
    assign wr_en_tag         = issue && head.mask[1];
    assign wr_en_hprot       = issue && head.mask[2];
    assign wr_en_state       = issue && head.mask[3];
    assign wr_en_evict_way   = issue && head.mask[4];
    assign wr_set            = head.set;
    assign wr_way            = head.way;
    assign wr_data_line      = head.line;
    assign wr_data_tag       = head.tag;
    assign wr_data_hprot     = head.hprot;
    assign wr_data_state     = head.state;
    assign wr_data_evict_way = head.evict_way;

    always_comb begin
        set_conflict = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (entry_valid[i] && (entry_set[i] == rd_set)) begin
                set_conflict = 1'b1;
            end
        end
        if (rst) begin
            set_conflict = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || issue || (count == '0)) begin
            stall_q <= '0;
        end else if (rd_mem_en && (stall_q != StallW'(STARVE_MAX))) begin
            stall_q <= stall_q + StallW'(1);
        end
    end

    assign force_drain = !rst && (stall_q == StallW'(STARVE_MAX));

endmodule
